// File: rtl/record_ctrl.sv
// rtl/record_ctrl.sv - record/playback sequencer for the note record memory
// Optional build macro: RECORD_CTRL_LOOP_EN (playback wraps to slot 0 instead of ending in IDLE).
module record_ctrl #(
  parameter int CNT_BITS  = 5,
  parameter int OCT_BITS  = 2,
  parameter int NOTE_BITS = 4,
  parameter int LEN_BITS  = 4,
  parameter int FULL_BITS = 3
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 rec_start_i,
  input  logic                 play_start_i,
  input  logic                 stop_i,
  input  logic                 tick_i,
  input  logic                 in_valid_i,
  input  logic [OCT_BITS-1:0]  in_octave_i,
  input  logic [NOTE_BITS-1:0] in_note_i,
  input  logic [LEN_BITS-1:0]  in_length_i,
  input  logic [FULL_BITS-1:0] in_full_note_i,
  output logic                 mem_en_o,
  output logic                 mem_rw_o,
  output logic [CNT_BITS-1:0]  mem_cnt_o,
  output logic [OCT_BITS-1:0]  mem_octave_o,
  output logic [NOTE_BITS-1:0] mem_note_o,
  output logic [LEN_BITS-1:0]  mem_length_o,
  output logic [FULL_BITS-1:0] mem_full_note_o,
  input  logic [OCT_BITS-1:0]  mem_octave_r_i,
  input  logic [NOTE_BITS-1:0] mem_note_r_i,
  input  logic [LEN_BITS-1:0]  mem_length_r_i,
  input  logic [FULL_BITS-1:0] mem_full_note_r_i,
  output logic                 out_valid_o,
  output logic [OCT_BITS-1:0]  out_octave_o,
  output logic [NOTE_BITS-1:0] out_note_o,
  output logic [FULL_BITS-1:0] out_full_note_o,
  output logic [1:0]           state_o,
  output logic [CNT_BITS:0]    rec_len_o,
  output logic                 full_o,
  output logic                 done_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REC  = 2'd1,
    S_LOAD = 2'd2,
    S_HOLD = 2'd3
  } state_e;

  localparam logic [CNT_BITS:0]   CAP     = {1'b1, {CNT_BITS{1'b0}}};
  localparam logic [CNT_BITS:0]   LEN_ONE = {{CNT_BITS{1'b0}}, 1'b1};
  localparam logic [CNT_BITS-1:0] PTR_ONE = {{(CNT_BITS-1){1'b0}}, 1'b1};
  localparam logic [LEN_BITS-1:0] HLD_ONE = {{(LEN_BITS-1){1'b0}}, 1'b1};

  state_e               state_q, state_d;
  logic [CNT_BITS-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, mem_cnt_q, mem_cnt_d;
  logic [CNT_BITS:0]    rec_len_q, rec_len_d;
  logic                 full_q, full_d, done_q, done_d;
  logic                 mem_en_q, mem_en_d, mem_rw_q, mem_rw_d;
  logic [OCT_BITS-1:0]  mem_oct_q, mem_oct_d, out_oct_q, out_oct_d;
  logic [NOTE_BITS-1:0] mem_note_q, mem_note_d, out_note_q, out_note_d;
  logic [LEN_BITS-1:0]  mem_len_q, mem_len_d, hold_q, hold_d;
  logic [FULL_BITS-1:0] mem_full_q, mem_full_d, out_full_q, out_full_d;
  logic                 out_valid_q, out_valid_d;
  logic                 wr_done;

  // The write strobe is a registered output, so the entry is counted as it leaves the bus.
  assign wr_done = mem_en_q & mem_rw_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      mem_cnt_q   <= '0;
      rec_len_q   <= '0;
      full_q      <= 1'b0;
      done_q      <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_rw_q    <= 1'b0;
      mem_oct_q   <= '0;
      mem_note_q  <= '0;
      mem_len_q   <= '0;
      mem_full_q  <= '0;
      out_valid_q <= 1'b0;
      out_oct_q   <= '0;
      out_note_q  <= '0;
      out_full_q  <= '0;
      hold_q      <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      mem_cnt_q   <= mem_cnt_d;
      rec_len_q   <= rec_len_d;
      full_q      <= full_d;
      done_q      <= done_d;
      mem_en_q    <= mem_en_d;
      mem_rw_q    <= mem_rw_d;
      mem_oct_q   <= mem_oct_d;
      mem_note_q  <= mem_note_d;
      mem_len_q   <= mem_len_d;
      mem_full_q  <= mem_full_d;
      out_valid_q <= out_valid_d;
      out_oct_q   <= out_oct_d;
      out_note_q  <= out_note_d;
      out_full_q  <= out_full_d;
      hold_q      <= hold_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    mem_cnt_d   = mem_cnt_q;
    rec_len_d   = rec_len_q;
    full_d      = full_q;
    done_d      = 1'b0;
    mem_en_d    = 1'b0;
    mem_rw_d    = 1'b0;
    mem_oct_d   = mem_oct_q;
    mem_note_d  = mem_note_q;
    mem_len_d   = mem_len_q;
    mem_full_d  = mem_full_q;
    out_valid_d = out_valid_q;
    out_oct_d   = out_oct_q;
    out_note_d  = out_note_q;
    out_full_d  = out_full_q;
    hold_d      = hold_q;

    if (wr_done) begin
      rec_len_d = rec_len_q + LEN_ONE;
      if (rec_len_q + LEN_ONE == CAP) full_d = 1'b1;
    end

    if (stop_i) begin
      state_d     = S_IDLE;
      out_valid_d = 1'b0;
    end else if (rec_start_i) begin
      state_d     = S_REC;
      wr_ptr_d    = '0;
      rec_len_d   = '0;
      full_d      = 1'b0;
      out_valid_d = 1'b0;
    end else if (play_start_i && state_q == S_IDLE && rec_len_d != '0) begin
      state_d   = S_LOAD;
      rd_ptr_d  = '0;
      mem_en_d  = 1'b1;
      mem_cnt_d = '0;
    end else begin
      unique case (state_q)
        S_REC: begin
          if (full_d) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else if (in_valid_i && in_length_i != '0) begin
            mem_en_d   = 1'b1;
            mem_rw_d   = 1'b1;
            mem_cnt_d  = wr_ptr_q;
            mem_oct_d  = in_octave_i;
            mem_note_d = in_note_i;
            mem_len_d  = in_length_i;
            mem_full_d = in_full_note_i;
            wr_ptr_d   = wr_ptr_q + PTR_ONE;
          end
        end
        S_LOAD: begin
          out_oct_d   = mem_octave_r_i;
          out_note_d  = mem_note_r_i;
          out_full_d  = mem_full_note_r_i;
          hold_d      = mem_length_r_i;
          out_valid_d = 1'b1;
          state_d     = S_HOLD;
        end
        S_HOLD: begin
          if (tick_i) begin
            if (hold_q <= HLD_ONE) begin
              if ({1'b0, rd_ptr_q} + LEN_ONE == rec_len_q) begin
                done_d = 1'b1;
`ifdef RECORD_CTRL_LOOP_EN
                rd_ptr_d  = '0;
                state_d   = S_LOAD;
                mem_en_d  = 1'b1;
                mem_cnt_d = '0;
`else
                state_d     = S_IDLE;
                out_valid_d = 1'b0;
`endif
              end else begin
                rd_ptr_d  = rd_ptr_q + PTR_ONE;
                state_d   = S_LOAD;
                mem_en_d  = 1'b1;
                mem_cnt_d = rd_ptr_q + PTR_ONE;
              end
            end else begin
              hold_d = hold_q - HLD_ONE;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign mem_en_o        = mem_en_q;
  assign mem_rw_o        = mem_rw_q;
  assign mem_cnt_o       = mem_cnt_q;
  assign mem_octave_o    = mem_oct_q;
  assign mem_note_o      = mem_note_q;
  assign mem_length_o    = mem_len_q;
  assign mem_full_note_o = mem_full_q;
  assign out_valid_o     = out_valid_q;
  assign out_octave_o    = out_oct_q;
  assign out_note_o      = out_note_q;
  assign out_full_note_o = out_full_q;
  assign state_o         = state_q;
  assign rec_len_o       = rec_len_q;
  assign full_o          = full_q;
  assign done_o          = done_q;

endmodule

// File: doc/record_ctrl.md
Name: record_ctrl

Overview:
Sequencer for the note record memory. Owns its single enable/rw/index port.
- Record mode: captures quantised note events from the keyboard path into consecutive slots.
- Play mode: reads slots back in order and holds each note for its stored length in beat ticks.
- Sits between the keyboard/mode FSM and the tone generator.

Parameters:
CNT_BITS, 5, slot index width; capacity 2^CNT_BITS entries
OCT_BITS, 2, octave field width
NOTE_BITS, 4, note field width
LEN_BITS, 4, length field width (beat ticks)
FULL_BITS, 3, full_note field width

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
rec_start  in  1  one-cycle pulse: begin a new recording
play_start  in  1  one-cycle pulse: begin playback
stop  in  1  one-cycle pulse: abort record/play
tick  in  1  one-cycle beat pulse
in_valid  in  1  one-cycle pulse: in_* fields hold a completed note
in_octave/in_note/in_length/in_full_note  in  OCT/NOTE/LEN/FULL_BITS  note to record
mem_en  out  1  memory enable; write strobe when mem_rw=1
mem_rw  out  1  1=write, 0=read
mem_cnt  out  CNT_BITS  memory slot index
mem_octave/mem_note/mem_length/mem_full_note  out  field widths  write data
mem_octave_r/mem_note_r/mem_length_r/mem_full_note_r  in  field widths  combinational read data at mem_cnt
out_valid  out  1  playback note active
out_octave/out_note/out_full_note  out  field widths  note being played
state  out  2  0=IDLE 1=REC 2=PLAY_LOAD 3=PLAY_HOLD
rec_len  out  CNT_BITS+1  stored entry count
full  out  1  rec_len == 2^CNT_BITS
done  out  1  one-cycle pulse: playback end or record-full stop

Behaviour:
Clock, reset and registering:
- One clock, clk. Reset is asynchronous and active-low on rst_n.
- All outputs are registered. Reset drives every output and internal pointer to 0 and state to IDLE.
- Command priority in every state: stop > rec_start > play_start.

IDLE:
- rec_start -> REC; wr_ptr=0, rec_len=0, full=0.
- play_start with rec_len!=0 -> PLAY_LOAD; rd_ptr=0.
- play_start with rec_len==0 is ignored.

REC:
- An in_valid with in_length!=0 and full=0 writes in the next cycle: mem_en=1, mem_rw=1, mem_cnt=wr_ptr, mem_* = captured in_* fields, for exactly one cycle. Then wr_ptr+1 and rec_len+1.
- in_valid with in_length==0 is ignored; no zero-length entry is ever stored.
- The write that makes rec_len = 2^CNT_BITS also sets full=1, returns to IDLE and pulses done on the following cycle.
- wr_ptr wraps to 0 but is never reused while full=1.
- stop -> IDLE; rec_len and memory contents are retained.
- rec_start while in REC restarts the recording from slot 0.

PLAY_LOAD (1 cycle):
- Drives mem_en=1, mem_rw=0, mem_cnt=rd_ptr.
- At the clock edge, latches the mem_*_r fields into out_*, sets hold=mem_length_r and out_valid=1, then -> PLAY_HOLD.

PLAY_HOLD:
- Each tick decrements hold.
- On a tick with hold==1: if rd_ptr+1 == rec_len, -> IDLE, out_valid=0, done=1 for one cycle. Otherwise rd_ptr+1 and -> PLAY_LOAD.
- out_valid stays 1 across PLAY_LOAD; out_* change only at a PLAY_LOAD edge.

General rules:
- stop in any PLAY state -> IDLE with out_valid=0 next cycle; done is not pulsed.
- stop and tick in the same cycle: stop wins.
- rec_start during play aborts playback and enters REC.
- mem_en is 0 in IDLE and whenever no access is in progress. mem_rw is 1 only during a write cycle.
- Latencies: in_valid -> memory write is 1 cycle. play_start -> out_valid is 2 cycles.

Optional Feature:
RECORD_CTRL_LOOP_EN
- Defined: at playback end, rd_ptr wraps to 0 and the FSM goes to PLAY_LOAD instead of IDLE. done pulses once per wrap, out_valid stays 1, and only stop or rec_start exits.
- Undefined: playback ends in IDLE as specified in Behaviour.

Test Plan:
- Record 3 notes (note 1/len 2, note 5/len 1, note 9/len 3), then stop. Required: three single-cycle writes at mem_cnt 0,1,2 with matching data; rec_len=3; state=0.
- play_start after that recording. Required: out_note 1 held for 2 ticks, then 5 for 1 tick, then 9 for 3 ticks; done pulses on the 6th tick; out_valid falls.
- CNT_BITS=2, four valid notes plus a fifth. Required: full=1 and done pulse after the 4th write; the fifth in_valid produces no write; rec_len=4.
- stop asserted in the same cycle as tick mid-hold. Required: next cycle state=0, out_valid=0, no done. in_valid with in_length=0 in REC produces no write.
- Assert rst_n low during PLAY_HOLD, asynchronously. Required: all outputs 0 and state IDLE immediately.
- With RECORD_CTRL_LOOP_EN, 2-note playback over 10 ticks. Required: sequence wraps to slot 0, one done pulse per wrap, out_valid never drops.
